// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg: shared encodings and load helpers for the data-memory stage |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Word index inside the 16-byte I/O window (address bits [3:2])
  localparam logic [1:0] MMIO_GPIO    = 2'd0;
  localparam logic [1:0] MMIO_TIMER   = 2'd1;
  localparam logic [1:0] MMIO_COMPARE = 2'd2;
  localparam logic [1:0] MMIO_STATUS  = 2'd3;

  localparam int unsigned STATUS_MATCH    = 0;
  localparam int unsigned STATUS_MISALIGN = 1;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  f3);
    logic [31:0] s;
    s = word >> {lo, 3'b000};
    if (misaligned(f3, lo)) return 32'h0;
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_W:    return s;
      F3_BU:   return {24'h0, s[7:0]};
      F3_HU:   return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_ram: MEM_WORDS x 32 synchronous RAM, byte-lane writes, read-first|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_mmio: RV32I data-memory stage with RAM and GPIO/timer MMIO   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_mmio
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int unsigned ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

  logic        w_in_ram, w_in_mmio, w_misaligned, w_store_f3;
  logic        w_store_ok, w_store_misaligned, w_mmio_wr;
  logic [1:0]  w_reg_sel, w_status_clr;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_wdata, w_ram_rdata, w_mmio_rdata;

  logic [31:0] r_gpio, r_timer, r_compare, r_mmio_rdata;
  logic [1:0]  r_status;
  region_e     r_region;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;

  assign w_in_ram           = Mem_WrAddr < RAM_BYTES;
  assign w_in_mmio          = Mem_WrAddr[31:4] == MMIO_BASE[31:4];
  assign w_misaligned       = misaligned(funct3, Mem_WrAddr[1:0]);
  assign w_store_f3         = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  assign w_store_ok         = MemWriteM && w_store_f3 && !w_misaligned;
  assign w_store_misaligned = MemWriteM && w_store_f3 && w_misaligned;
  assign w_reg_sel          = Mem_WrAddr[3:2];
  assign w_mmio_wr          = w_store_ok && w_in_mmio && (funct3 == F3_W);
  assign w_status_clr       = (w_mmio_wr && (w_reg_sel == MMIO_STATUS)) ? Mem_WrData[1:0] : 2'b00;

  // Store data is replicated across lanes so the enable alone picks the target bytes
  always_comb begin
    w_ram_we    = 4'b0000;
    w_ram_wdata = Mem_WrData;
    if (w_store_ok && w_in_ram) begin
      case (funct3)
        F3_B: begin
          w_ram_we    = 4'b0001 << Mem_WrAddr[1:0];
          w_ram_wdata = {4{Mem_WrData[7:0]}};
        end
        F3_H: begin
          w_ram_we    = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
          w_ram_wdata = {2{Mem_WrData[15:0]}};
        end
        default: w_ram_we = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (w_reg_sel)
      MMIO_GPIO:    w_mmio_rdata = r_gpio;
      MMIO_TIMER:   w_mmio_rdata = r_timer;
      MMIO_COMPARE: w_mmio_rdata = r_compare;
      default:      w_mmio_rdata = {30'h0, r_status};
    endcase
  end

  dmem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (Mem_WrAddr[ADDR_W+1:2]),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio       <= 32'h0;
      r_timer      <= 32'h0;
      r_compare    <= 32'hFFFF_FFFF;
      r_status     <= 2'b00;
      r_region     <= REGION_NONE;
      r_addr_lo    <= 2'b00;
      r_funct3     <= 3'b000;
      r_mmio_rdata <= 32'h0;
    end else begin
      r_timer <= (w_mmio_wr && (w_reg_sel == MMIO_TIMER)) ? Mem_WrData : r_timer + 32'd1;
      if (w_mmio_wr && (w_reg_sel == MMIO_GPIO))    r_gpio    <= Mem_WrData;
      if (w_mmio_wr && (w_reg_sel == MMIO_COMPARE)) r_compare <= Mem_WrData;
      // Set terms are OR-ed after the clear so a coincident match beats W1C
      r_status[STATUS_MATCH] <= (r_status[STATUS_MATCH] & ~w_status_clr[STATUS_MATCH])
                                | (r_timer == r_compare);
      r_status[STATUS_MISALIGN] <= (r_status[STATUS_MISALIGN] & ~w_status_clr[STATUS_MISALIGN])
                                   | w_store_misaligned;
      r_region     <= w_in_ram ? REGION_RAM : (w_in_mmio ? REGION_MMIO : REGION_NONE);
      r_addr_lo    <= Mem_WrAddr[1:0];
      r_funct3     <= funct3;
      r_mmio_rdata <= w_mmio_rdata;
    end
  end

  always_comb begin
    case (r_region)
      REGION_RAM:  ReadData = load_extend(w_ram_rdata, r_addr_lo, r_funct3);
      REGION_MMIO: ReadData = load_extend(r_mmio_rdata, r_addr_lo, r_funct3);
      default:     ReadData = 32'h0;
    endcase
  end

  assign gpio_out  = r_gpio;
  assign timer_irq = r_status[STATUS_MATCH];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_data_mem_mmio: vector table, directed corners and random vs model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_mmio;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO    = 32'hFFFF_0000;
  localparam logic [31:0] A_TIMER   = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP     = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT    = 32'hFFFF_000C;
  localparam logic [31:0] A_NONE    = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [31:0] addr, wdata, rd, gpio;
  logic [2:0]  f3;
  logic        irq;

  always #5 clk = ~clk;

  data_mem_mmio #(
    .MEM_WORDS (MEM_WORDS),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (we),
    .Mem_WrAddr (addr),
    .Mem_WrData (wdata),
    .funct3     (f3),
    .ReadData   (rd),
    .gpio_out   (gpio),
    .timer_irq  (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed RAM and plain register variables
  logic [7:0]  m_mem [4096];
  logic [31:0] m_gpio, m_timer, m_cmp, m_rd;
  logic [1:0]  m_status;

  function automatic int acc_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_status = 0; m_rd = 0;
  endtask

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f);
    int          sz, idx, off;
    logic [31:0] reg_val, val, nt;
    logic        is_ram, is_io, match, mis;
    logic [1:0]  clr;
    sz     = acc_size(f);
    is_ram = a < 32'(4 * MEM_WORDS);
    is_io  = (a >> 4) == (MMIO_BASE >> 4);
    idx    = int'(a & 32'hFFF);
    off    = int'(a % 4);
    case (int'((a >> 2) % 4))
      0:       reg_val = m_gpio;
      1:       reg_val = m_timer;
      2:       reg_val = m_cmp;
      default: reg_val = {30'h0, m_status};
    endcase
    val = 0;
    if (sz != 0 && (off % sz) == 0 && (is_ram || is_io)) begin
      for (int k = 0; k < sz; k++) begin
        if (is_ram) val = val | (32'(m_mem[idx + k]) << (8 * k));
        else        val = val | (32'(8'(reg_val >> (8 * (off + k)))) << (8 * k));
      end
      if (f == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
      if (f == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
    end
    m_rd  = val;
    match = (m_timer == m_cmp);
    mis   = 0;
    clr   = 0;
    nt    = m_timer + 1;
    if (w && f <= 3'b010) begin
      if ((off % sz) != 0) mis = 1;
      else if (is_ram) begin
        for (int k = 0; k < sz; k++) m_mem[idx + k] = 8'(d >> (8 * k));
      end else if (is_io && sz == 4) begin
        case (int'((a >> 2) % 4))
          0:       m_gpio = d;
          1:       nt     = d;
          2:       m_cmp  = d;
          default: clr    = d[1:0];
        endcase
      end
    end
    m_timer     = nt;
    m_status[0] = (m_status[0] & ~clr[0]) | match;
    m_status[1] = (m_status[1] & ~clr[1]) | mis;
  endtask

  // One bus cycle: drive at negedge, DUT samples at posedge, caller checks at next negedge
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    we = w; addr = a; wdata = d; f3 = f;
    model_step(w, a, d, f);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    reset = 1'b1; we = w; addr = a; wdata = d; f3 = f;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          ftab[10];
    int          r;
    logic [31:0] a, d;
    logic        w;
    logic [2:0]  f;
    ftab = '{0, 1, 2, 4, 5, 2, 2, 3, 6, 7};

    tbl.push_back('{1, 32'h14, 32'h0BAD_F00D, 3'b010, 0, 32'h0, "sw_14"});
    tbl.push_back('{1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, 32'h0, "sw_10"});
    tbl.push_back('{0, 32'h11, 32'h0, 3'b000, 1, 32'hFFFF_FFBE, "lb_11"});
    tbl.push_back('{0, 32'h11, 32'h0, 3'b100, 1, 32'h0000_00BE, "lbu_11"});
    tbl.push_back('{0, 32'h12, 32'h0, 3'b001, 1, 32'hFFFF_DEAD, "lh_12"});
    tbl.push_back('{0, 32'h12, 32'h0, 3'b101, 1, 32'h0000_DEAD, "lhu_12"});
    tbl.push_back('{0, 32'h10, 32'h0, 3'b010, 1, 32'hDEAD_BEEF, "lw_10"});
    tbl.push_back('{1, 32'h13, 32'h55, 3'b000, 1, 32'hFFFF_FFDE, "sb_13_readfirst"});
    tbl.push_back('{0, 32'h10, 32'h0, 3'b010, 1, 32'h55AD_BEEF, "lw_after_sb"});
    tbl.push_back('{1, 32'h10, 32'h1234, 3'b001, 1, 32'hFFFF_BEEF, "sh_10_readfirst"});
    tbl.push_back('{0, 32'h10, 32'h0, 3'b010, 1, 32'h55AD_1234, "lw_after_sh"});
    tbl.push_back('{1, 32'h16, 32'h1111_1111, 3'b010, 1, 32'h0, "sw_misaligned"});
    tbl.push_back('{1, 32'h11, 32'h2222, 3'b001, 1, 32'h0, "sh_misaligned"});
    tbl.push_back('{0, 32'h14, 32'h0, 3'b010, 1, 32'h0BAD_F00D, "lw_14_unchanged"});
    tbl.push_back('{0, 32'h10, 32'h0, 3'b010, 1, 32'h55AD_1234, "lw_10_unchanged"});
    tbl.push_back('{0, A_STAT, 32'h0, 3'b010, 1, 32'h2, "status_misalign"});
    tbl.push_back('{1, A_STAT, 32'h2, 3'b010, 1, 32'h2, "status_w1c_readfirst"});
    tbl.push_back('{0, A_STAT, 32'h0, 3'b010, 1, 32'h0, "status_cleared"});
    tbl.push_back('{1, A_GPIO, 32'hA5A5_A5A5, 3'b010, 1, 32'h0, "gpio_sw_readfirst"});
    tbl.push_back('{0, A_GPIO, 32'h0, 3'b010, 1, 32'hA5A5_A5A5, "gpio_lw"});
    tbl.push_back('{0, A_GPIO + 1, 32'h0, 3'b100, 1, 32'h0000_00A5, "gpio_lbu_1"});
    tbl.push_back('{0, A_GPIO + 2, 32'h0, 3'b001, 1, 32'hFFFF_A5A5, "gpio_lh_2"});
    tbl.push_back('{1, A_GPIO, 32'h0, 3'b000, 1, 32'hFFFF_FFA5, "gpio_sb_ignored"});
    tbl.push_back('{0, A_GPIO, 32'h0, 3'b010, 1, 32'hA5A5_A5A5, "gpio_after_sb"});
    tbl.push_back('{0, A_NONE, 32'h0, 3'b010, 1, 32'h0, "unmapped_lw"});
    tbl.push_back('{0, 32'h10, 32'h0, 3'b011, 1, 32'h0, "undef_funct3"});
    tbl.push_back('{0, 32'h12, 32'h0, 3'b010, 1, 32'h0, "misaligned_lw"});
    tbl.push_back('{1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 0, 32'h0, "sw_last_word"});
    tbl.push_back('{0, 32'hFFC, 32'h0, 3'b010, 1, 32'hCAFE_F00D, "lw_last_word"});
    tbl.push_back('{0, 32'h1000, 32'h0, 3'b010, 1, 32'h0, "lw_past_ram"});

    reset = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; f3 = 3'b000;
    @(negedge clk);
    rst_cyc(1'b0, 32'h0, 32'h0, 3'b010);
    check("reset_readdata", rd, 32'h0);
    check("reset_gpio", gpio, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f);
      if (tbl[i].chk) check(tbl[i].name, rd, tbl[i].exp);
    end
    check("gpio_out_value", gpio, 32'hA5A5_A5A5);

    // Compare match: COMPARE=20, TIMER=10; bit0 sets at the edge where TIMER is 20
    cyc(1'b1, A_CMP, 32'd20, 3'b010);
    check("compare_readfirst", rd, 32'hFFFF_FFFF);
    cyc(1'b1, A_TIMER, 32'd10, 3'b010);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, A_TIMER, 32'h0, 3'b010);
      check("timer_count", rd, 32'(10 + i));
      check("irq_vs_timer", {31'h0, irq}, {31'h0, (10 + i) >= 20});
    end
    cyc(1'b1, A_STAT, 32'h1, 3'b010);
    check("status_before_w1c", rd, 32'h1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    cyc(1'b1, A_CMP, 32'd100, 3'b010);
    cyc(1'b1, A_TIMER, 32'd98, 3'b010);
    cyc(1'b0, A_NONE, 32'h0, 3'b010);
    cyc(1'b0, A_NONE, 32'h0, 3'b010);
    cyc(1'b1, A_STAT, 32'h1, 3'b010);
    check("set_beats_w1c_irq", {31'h0, irq}, 32'h1);
    cyc(1'b0, A_STAT, 32'h0, 3'b010);
    check("set_beats_w1c_status", rd, 32'h1);

    // Timer wrap
    cyc(1'b1, A_TIMER, 32'hFFFF_FFFE, 3'b010);
    cyc(1'b0, A_TIMER, 32'h0, 3'b010);
    check("timer_wrap_0", rd, 32'hFFFF_FFFE);
    cyc(1'b0, A_TIMER, 32'h0, 3'b010);
    check("timer_wrap_1", rd, 32'hFFFF_FFFF);
    cyc(1'b0, A_TIMER, 32'h0, 3'b010);
    check("timer_wrap_2", rd, 32'h0);

    // Reset mid-count with a coincident GPIO store that must be discarded
    cyc(1'b0, A_GPIO, 32'h0, 3'b010);
    check("pre_reset_gpio_read", rd, 32'hA5A5_A5A5);
    rst_cyc(1'b1, A_GPIO, 32'h1234_5678, 3'b010);
    check("midreset_readdata", rd, 32'h0);
    check("midreset_gpio", gpio, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    cyc(1'b0, A_TIMER, 32'h0, 3'b010);
    check("midreset_timer", rd, 32'h0);
    cyc(1'b0, A_STAT, 32'h0, 3'b010);
    check("midreset_status", rd, 32'h0);

    // Random traffic against the model over a fully written RAM window
    for (int i = 0; i < 64; i++) cyc(1'b1, 32'(4 * i), $urandom, 3'b010);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = 32'($urandom_range(0, 255));
      else if (r < 9) a = MMIO_BASE + 32'($urandom_range(0, 15));
      else            a = 32'h8000_0000 | $urandom;
      f = 3'(ftab[$urandom_range(0, 9)]);
      w = ($urandom_range(0, 2) == 0);
      d = (r >= 6 && r < 9 && $urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      cyc(w, a, d, f);
      check("rand_readdata", rd, m_rd);
      check("rand_gpio", gpio, m_gpio);
      check("rand_irq", {31'h0, irq}, {31'h0, m_status[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
